ball_trajectory_predictor: RTL and testbench
============================================

Name: ball_trajectory_predictor

Overview:
- Downstream consumer of the per-frame ball grid position produced by the ball detection stage (40 columns x 30 rows, 16x16-pixel blocks).
- Tracks the ball across frames and derives a per-frame velocity in blocks/frame.
- Steps the trajectory forward, with reflection off the top and bottom walls, until it reaches the paddle column.
- Emits the predicted row as the paddle target for the motor/paddle controller.

Parameters:
- GRID_W, 40, grid columns
- GRID_H, 30, grid rows
- PADDLE_COL, 38, column where the paddle intercepts
- CENTER_Y, 15, home row when there is no valid prediction
- MAX_SPEED, 6, maximum plausible |velocity| per axis, in blocks/frame
- MAX_MISS, 4, consecutive missed frames before track loss
- MAX_STEPS, 63, cap on prediction iterations

Ports:
- CLK, in, 1, system clock
- RST, in, 1, asynchronous active-high reset
- BALL_VALID, in, 1, one-cycle pulse per frame; position fields valid with it
- BALL_FOUND, in, 1, ball detected this frame
- BALL_X, in, 6, ball column, 0..GRID_W-1
- BALL_Y, in, 5, ball row, 0..GRID_H-1
- TARGET_Y, out, 5, predicted intercept row
- TARGET_VALID, out, 1, one-cycle pulse when TARGET_Y is updated
- TRACKING, out, 1, velocity estimate valid
- VEL_X, out, 7, signed column velocity
- VEL_Y, out, 7, signed row velocity
- BUSY, out, 1, update/prediction in progress

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-high.
- Reset values: TARGET_Y=CENTER_Y, TARGET_VALID=0, TRACKING=0, VEL_X=VEL_Y=0, BUSY=0. Internally: state=IDLE, have_prev=0, miss_cnt=0, pending=0.
- States: IDLE, UPDATE, PREDICT, DONE.
- IDLE:
  - BALL_VALID at cycle t: latch the sample and go to UPDATE at t+1.
  - BUSY is high in every state except IDLE.
- UPDATE (one cycle):
  - FOUND, have_prev=1, miss_cnt=0: dx=X-prev_x, dy=Y-prev_y, as 7-bit signed.
    - If |dx|>MAX_SPEED or |dy|>MAX_SPEED, treat as a jump: TRACKING=0, velocities cleared.
    - Otherwise VEL_X=dx, VEL_Y=dy, TRACKING=1.
  - FOUND and (have_prev=0 or miss_cnt>0): reseed. prev=(X,Y), have_prev=1, miss_cnt=0. TRACKING and velocity are held; no prediction is made.
  - Not FOUND: miss_cnt++ (saturating). When it reaches MAX_MISS: TRACKING=0, velocities=0, have_prev=0, TARGET_Y=CENTER_Y with a TARGET_VALID pulse. No other prediction.
  - On every FOUND sample, prev is updated to the current position.
  - Next state:
    - Tracking with VEL_X>0: PREDICT, stepper seeded with (X,Y,VEL_Y), step_cnt=0.
    - Tracking with VEL_X<=0: DONE with target=CENTER_Y.
    - Any other case: IDLE, or DONE when a track-loss pulse is required.
- PREDICT, one step per cycle:
  - x+=VEL_X; yn=y+vy.
  - yn<0: y=-yn, vy=-vy.
  - yn>GRID_H-1: y=2*(GRID_H-1)-yn, vy=-vy.
  - MAX_SPEED<GRID_H guarantees a single reflection per step.
  - Exit to DONE when x>=PADDLE_COL after the step, or when step_cnt reaches MAX_STEPS. In the cap case the target is the current y.
- DONE (one cycle): TARGET_Y registered and TARGET_VALID=1, then IDLE.
- Latency:
  - Non-predicting update: TARGET_VALID at t+2.
  - Prediction of k steps: TARGET_VALID at t+2+k.
- BALL_VALID while BUSY:
  - The sample is stored in a one-deep pending register; a newer one overwrites it.
  - It is consumed on the cycle after DONE (IDLE acts as if BALL_VALID were present).
- Simultaneous BALL_VALID and DONE: the sample goes to pending and is consumed next cycle. No sample is lost except by overwrite.
- RST mid-operation: immediate return to reset values. The in-flight prediction is discarded and no TARGET_VALID is issued.
- Arithmetic: position intermediates are 8-bit signed. Out-of-range BALL_X/BALL_Y inputs are clamped to the grid on latch.

Decomposition:
- Package ball_track_pkg holds:
  - GRID_W, GRID_H, CENTER_Y
  - coordinate/velocity typedefs (col_t 6b, row_t 5b, vel_t 7b signed)
  - state enum {IDLE, UPDATE, PREDICT, DONE}
- Sub-module trajectory_stepper: load/seed inputs, registered x/y/vy, single-step with wall reflection, and a done flag. It is instantiated by the top-level FSM.

Test Plan:
- Straight shot: found (10,10) then (12,11) -> VEL=(2,1), TRACKING=1, TARGET_Y=24, TARGET_VALID 13 steps after UPDATE (t+15).
- Bounce: (20,25) then (23,28), VEL=(3,3) -> y sequence 27,24,21,18,15; TARGET_Y=15 at t+7.
- Ball moving away: (30,10) then (28,12) -> VEL_X=-2, TARGET_Y=15, TARGET_VALID at t+2.
- Track loss: tracking, then 4 frames not found -> TRACKING falls and VEL=0 on the 4th UPDATE, TARGET_Y=15 pulsed. 3 misses followed by found reseeds instead, with TRACKING still 1.
- Jump rejection: (10,10) then (20,10) -> TRACKING=0, no TARGET_VALID. A following (21,10) -> VEL=(1,0), TRACKING=1.
- Pending/reset: BALL_VALID during PREDICT -> processed immediately after DONE. RST asserted mid-PREDICT -> all outputs at reset values the same cycle, no TARGET_VALID.

Source files
------------

// File: rtl/ball_track_pkg.sv
// Shared grid geometry, coordinate/velocity types and FSM states for the ball tracker.
// Input clamping and speed-plausibility helpers live here so every stage agrees on them.
package ball_track_pkg;
  localparam int GRID_W     = 40;
  localparam int GRID_H     = 30;
  localparam int PADDLE_COL = 38;
  localparam int CENTER_Y   = 15;
  localparam int MAX_SPEED  = 6;
  localparam int MAX_MISS   = 4;
  localparam int MAX_STEPS  = 63;

  typedef logic [5:0]        col_t;
  typedef logic [4:0]        row_t;
  typedef logic signed [6:0] vel_t;

  typedef enum logic [1:0] {IDLE, UPDATE, PREDICT, DONE} state_t;

  function automatic col_t clamp_col(input logic [5:0] x);
    return (x > 6'(GRID_W - 1)) ? col_t'(GRID_W - 1) : x;
  endfunction

  function automatic row_t clamp_row(input logic [4:0] y);
    return (y > 5'(GRID_H - 1)) ? row_t'(GRID_H - 1) : y;
  endfunction

  function automatic logic too_fast(input vel_t v);
    vel_t a;
    a = v[6] ? -v : v;
    return a > vel_t'(MAX_SPEED);
  endfunction
endpackage

// File: rtl/ball_trajectory_predictor_if.sv
// Detection-sample input and paddle-target output bundle of the trajectory predictor.
interface ball_trajectory_predictor_if;
  import ball_track_pkg::*;

  logic       BALL_VALID;
  logic       BALL_FOUND;
  logic [5:0] BALL_X;
  logic [4:0] BALL_Y;
  row_t       TARGET_Y;
  logic       TARGET_VALID;
  logic       TRACKING;
  vel_t       VEL_X;
  vel_t       VEL_Y;
  logic       BUSY;

  modport master (output BALL_VALID, BALL_FOUND, BALL_X, BALL_Y,
                  input  TARGET_Y, TARGET_VALID, TRACKING, VEL_X, VEL_Y, BUSY);
  modport slave  (input  BALL_VALID, BALL_FOUND, BALL_X, BALL_Y,
                  output TARGET_Y, TARGET_VALID, TRACKING, VEL_X, VEL_Y, BUSY);
endinterface

// File: rtl/trajectory_stepper.sv
// Advances the ball one frame per step with top/bottom wall reflection.
// y_nxt/hit describe the step about to be taken so the caller can stop without a bubble.
module trajectory_stepper
  import ball_track_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic load,
  input  logic step,
  input  col_t seed_x,
  input  row_t seed_y,
  input  vel_t seed_vx,
  input  vel_t seed_vy,
  output row_t y_nxt,
  output logic hit
);
  localparam logic signed [7:0] Y_MAX  = 8'(GRID_H - 1);
  localparam logic signed [7:0] X_PAD  = 8'(PADDLE_COL);
  localparam row_t              Y_REFL = row_t'(2 * (GRID_H - 1));

  logic signed [7:0] x, xn, yn;
  row_t y, y_lo;
  vel_t vx, vy, vyn;

  // Reflected rows always land back in 0..GRID_H-1, so 5-bit modular math is exact.
  always_comb begin
    xn    = x + {vx[6], vx};
    yn    = $signed({3'b000, y}) + {vy[6], vy};
    y_lo  = y + vy[4:0];
    y_nxt = y_lo;
    vyn   = vy;
    if (yn < 8'sd0) begin
      y_nxt = -y_lo;
      vyn   = -vy;
    end else if (yn > Y_MAX) begin
      y_nxt = Y_REFL - y_lo;
      vyn   = -vy;
    end
    hit = (xn >= X_PAD);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      x  <= '0;
      y  <= '0;
      vx <= '0;
      vy <= '0;
    end else if (load) begin
      x  <= {2'b00, seed_x};
      y  <= seed_y;
      vx <= seed_vx;
      vy <= seed_vy;
    end else if (step) begin
      x  <= xn;
      y  <= y_nxt;
      vy <= vyn;
    end
  end
endmodule

// File: rtl/ball_trajectory_predictor.sv
// Tracks the detected ball, estimates velocity and predicts the paddle-column intercept row.
// Samples arriving while busy park in a one-deep pending slot (newest wins).
module ball_trajectory_predictor
  import ball_track_pkg::*;
(
  input  logic                        CLK,
  input  logic                        RST,
  ball_trajectory_predictor_if.slave  bus
);
  localparam logic [2:0] MISS_LIM  = 3'(MAX_MISS);
  localparam logic [5:0] STEP_LAST = 6'(MAX_STEPS - 1);
  localparam row_t       HOME_ROW  = row_t'(CENTER_Y);

  state_t     state;
  logic       have_prev, pend_vld, pend_found, cur_found;
  logic [2:0] miss_cnt;
  logic [5:0] step_cnt;
  col_t       pend_x, cur_x, prev_x;
  row_t       pend_y, cur_y, prev_y, target_y, y_nxt;
  logic       target_vld, tracking, busy;
  vel_t       vel_x, vel_y, dx, dy;
  logic       vel_upd, jump, start_pred, step_en, hit, pred_end;

  always_comb begin
    dx         = vel_t'({1'b0, cur_x}) - vel_t'({1'b0, prev_x});
    dy         = vel_t'({2'b00, cur_y}) - vel_t'({2'b00, prev_y});
    jump       = too_fast(dx) || too_fast(dy);
    vel_upd    = cur_found && have_prev && (miss_cnt == 3'd0);
    start_pred = (state == UPDATE) && vel_upd && !jump && (dx > vel_t'(0));
    step_en    = (state == PREDICT);
    pred_end   = hit || (step_cnt == STEP_LAST);
  end

  trajectory_stepper u_stepper (
    .CLK     (CLK),
    .RST     (RST),
    .load    (start_pred),
    .step    (step_en),
    .seed_x  (cur_x),
    .seed_y  (cur_y),
    .seed_vx (dx),
    .seed_vy (dy),
    .y_nxt   (y_nxt),
    .hit     (hit)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      have_prev  <= 1'b0;
      miss_cnt   <= '0;
      pend_vld   <= 1'b0;
      pend_found <= 1'b0;
      pend_x     <= '0;
      pend_y     <= '0;
      cur_found  <= 1'b0;
      cur_x      <= '0;
      cur_y      <= '0;
      prev_x     <= '0;
      prev_y     <= '0;
      step_cnt   <= '0;
      target_y   <= HOME_ROW;
      target_vld <= 1'b0;
      tracking   <= 1'b0;
      vel_x      <= '0;
      vel_y      <= '0;
      busy       <= 1'b0;
    end else begin
      target_vld <= 1'b0;
      if (bus.BALL_VALID && state != IDLE) begin
        pend_vld   <= 1'b1;
        pend_found <= bus.BALL_FOUND;
        pend_x     <= clamp_col(bus.BALL_X);
        pend_y     <= clamp_row(bus.BALL_Y);
      end
      case (state)
        IDLE: begin
          // A live sample is newer than the parked one, so it takes precedence.
          if (bus.BALL_VALID) begin
            cur_found <= bus.BALL_FOUND;
            cur_x     <= clamp_col(bus.BALL_X);
            cur_y     <= clamp_row(bus.BALL_Y);
            pend_vld  <= 1'b0;
            state     <= UPDATE;
            busy      <= 1'b1;
          end else if (pend_vld) begin
            cur_found <= pend_found;
            cur_x     <= pend_x;
            cur_y     <= pend_y;
            pend_vld  <= 1'b0;
            state     <= UPDATE;
            busy      <= 1'b1;
          end
        end
        UPDATE: begin
          if (cur_found) begin
            prev_x    <= cur_x;
            prev_y    <= cur_y;
            have_prev <= 1'b1;
            miss_cnt  <= '0;
            if (vel_upd && jump) begin
              tracking <= 1'b0;
              vel_x    <= '0;
              vel_y    <= '0;
              state    <= IDLE;
              busy     <= 1'b0;
            end else if (vel_upd) begin
              vel_x    <= dx;
              vel_y    <= dy;
              tracking <= 1'b1;
              step_cnt <= '0;
              if (start_pred) begin
                state <= PREDICT;
              end else begin
                state      <= DONE;
                target_y   <= HOME_ROW;
                target_vld <= 1'b1;
              end
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            if (miss_cnt != MISS_LIM) miss_cnt <= miss_cnt + 3'd1;
            if (miss_cnt == MISS_LIM - 3'd1) begin
              tracking   <= 1'b0;
              vel_x      <= '0;
              vel_y      <= '0;
              have_prev  <= 1'b0;
              state      <= DONE;
              target_y   <= HOME_ROW;
              target_vld <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        PREDICT: begin
          step_cnt <= step_cnt + 6'd1;
          if (pred_end) begin
            state      <= DONE;
            target_y   <= y_nxt;
            target_vld <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.TARGET_Y     = target_y;
  assign bus.TARGET_VALID = target_vld;
  assign bus.TRACKING     = tracking;
  assign bus.VEL_X        = vel_x;
  assign bus.VEL_Y        = vel_y;
  assign bus.BUSY         = busy;
endmodule

// File: tb/tb_ball_trajectory_predictor.sv
// Scoreboarded bench: expected target pulses (row + cycle) are queued at stimulus time.
module tb_ball_trajectory_predictor;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  typedef struct {
    int y;
    int cyc;
  } exp_t;
  exp_t sb[$];

  ball_trajectory_predictor_if bus();

  ball_trajectory_predictor dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (bus.TARGET_VALID === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL target_unexpected got row=%0d at cycle %0d want no pulse", bus.TARGET_Y, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.TARGET_Y !== 5'(e.y) || cyc != e.cyc)
          $display("FAIL target got row=%0d cycle=%0d want row=%0d cycle=%0d",
                   bus.TARGET_Y, cyc, e.y, e.cyc);
        else
          passes++;
      end
    end
  end

  task automatic push(input int y, input int c);
    exp_t e;
    e.y = y;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    sb.delete();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic send_at(input int edge_n, input logic f, input logic [5:0] x,
                         input logic [4:0] y, output int n);
    do @(negedge CLK); while (cyc + 1 < edge_n);
    bus.BALL_VALID = 1'b1;
    bus.BALL_FOUND = f;
    bus.BALL_X     = x;
    bus.BALL_Y     = y;
    n = cyc + 1;
    @(negedge CLK);
    bus.BALL_VALID = 1'b0;
  endtask

  task automatic send(input logic f, input logic [5:0] x, input logic [4:0] y, output int n);
    send_at(0, f, x, y, n);
  endtask

  task automatic wait_idle(input string tag);
    int budget;
    budget = 300;
    while ((bus.BUSY !== 1'b0 || sb.size() != 0) && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    if (budget == 0) begin
      checks++;
      $display("FAIL %s_timeout got busy=%b pending_expect=%0d want idle", tag, bus.BUSY, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    checks += 5;
    if (bus.TARGET_Y !== 5'd15) $display("FAIL reset_target got %0d want 15", bus.TARGET_Y); else passes++;
    if (bus.TARGET_VALID !== 1'b0) $display("FAIL reset_tvalid got %b want 0", bus.TARGET_VALID); else passes++;
    if (bus.TRACKING !== 1'b0) $display("FAIL reset_tracking got %b want 0", bus.TRACKING); else passes++;
    if (bus.VEL_X !== 7'd0 || bus.VEL_Y !== 7'd0)
      $display("FAIL reset_vel got %0d,%0d want 0,0", bus.VEL_X, bus.VEL_Y); else passes++;
    if (bus.BUSY !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.BUSY); else passes++;
    RST = 1'b0;
  endtask

  task automatic test_straight();
    int n;
    do_reset();
    send(1, 10, 10, n); wait_idle("straight_seed");
    send(1, 12, 11, n); push(24, n + 14);
    checks++;
    if (bus.BUSY !== 1'b1) $display("FAIL straight_busy got %b want 1", bus.BUSY); else passes++;
    wait_idle("straight");
    checks += 2;
    if (bus.TRACKING !== 1'b1) $display("FAIL straight_tracking got %b want 1", bus.TRACKING); else passes++;
    if (bus.VEL_X !== 7'sd2 || bus.VEL_Y !== 7'sd1)
      $display("FAIL straight_vel got %0d,%0d want 2,1", bus.VEL_X, bus.VEL_Y); else passes++;
  endtask

  task automatic test_bounce();
    int n;
    do_reset();
    send(1, 20, 25, n); wait_idle("bounce_seed");
    send(1, 23, 28, n); push(15, n + 6);
    wait_idle("bounce");
    checks++;
    if (bus.VEL_Y !== 7'sd3) $display("FAIL bounce_vel_y got %0d want 3", bus.VEL_Y); else passes++;
  endtask

  task automatic test_away();
    int n;
    do_reset();
    send(1, 30, 10, n); wait_idle("away_seed");
    send(1, 28, 12, n); push(15, n + 1);
    wait_idle("away");
    checks++;
    if (bus.VEL_X !== -7'sd2 || bus.VEL_Y !== 7'sd2)
      $display("FAIL away_vel got %0d,%0d want -2,2", bus.VEL_X, bus.VEL_Y); else passes++;
  endtask

  task automatic test_clamp();
    int n;
    do_reset();
    send(1, 63, 31, n); wait_idle("clamp_seed");
    send(1, 37, 29, n); push(15, n + 1);
    wait_idle("clamp");
    checks++;
    if (bus.VEL_X !== -7'sd2 || bus.VEL_Y !== 7'sd0)
      $display("FAIL clamp_vel got %0d,%0d want -2,0", bus.VEL_X, bus.VEL_Y); else passes++;
  endtask

  task automatic test_track_loss();
    int n;
    do_reset();
    send(1, 10, 10, n); wait_idle("loss_seed");
    send(1, 12, 11, n); push(24, n + 14); wait_idle("loss_track");
    for (int i = 0; i < 3; i++) begin
      send(0, 0, 0, n); wait_idle("loss_miss");
    end
    checks++;
    if (bus.TRACKING !== 1'b1) $display("FAIL loss_3miss_tracking got %b want 1", bus.TRACKING); else passes++;
    send(0, 0, 0, n); push(15, n + 1); wait_idle("loss_4th");
    checks += 2;
    if (bus.TRACKING !== 1'b0) $display("FAIL loss_tracking got %b want 0", bus.TRACKING); else passes++;
    if (bus.VEL_X !== 7'd0 || bus.VEL_Y !== 7'd0)
      $display("FAIL loss_vel got %0d,%0d want 0,0", bus.VEL_X, bus.VEL_Y); else passes++;

    do_reset();
    send(1, 10, 10, n); wait_idle("reseed_seed");
    send(1, 12, 11, n); push(24, n + 14); wait_idle("reseed_track");
    for (int i = 0; i < 3; i++) begin
      send(0, 0, 0, n); wait_idle("reseed_miss");
    end
    send(1, 20, 20, n); wait_idle("reseed");
    checks++;
    if (bus.TRACKING !== 1'b1 || bus.VEL_X !== 7'sd2)
      $display("FAIL reseed_hold got trk=%b vx=%0d want trk=1 vx=2", bus.TRACKING, bus.VEL_X); else passes++;
    send(1, 22, 21, n); push(29, n + 9); wait_idle("reseed_next");
  endtask

  task automatic test_jump();
    int n;
    do_reset();
    send(1, 10, 10, n); wait_idle("jump_seed");
    send(1, 20, 10, n); wait_idle("jump");
    checks++;
    if (bus.TRACKING !== 1'b0 || bus.VEL_X !== 7'd0)
      $display("FAIL jump_reject got trk=%b vx=%0d want trk=0 vx=0", bus.TRACKING, bus.VEL_X); else passes++;
    send(1, 21, 10, n); push(10, n + 18); wait_idle("jump_next");
    checks++;
    if (bus.TRACKING !== 1'b1 || bus.VEL_X !== 7'sd1 || bus.VEL_Y !== 7'sd0)
      $display("FAIL jump_recover got trk=%b vel=%0d,%0d want trk=1 vel=1,0",
               bus.TRACKING, bus.VEL_X, bus.VEL_Y); else passes++;
  endtask

  task automatic test_back_to_back();
    int n, m, d2;
    do_reset();
    send(1, 10, 10, n); wait_idle("b2b_seed");
    send(1, 12, 11, n); push(24, n + 14);
    send_at(n + 5, 1, 14, 12, m); push(24, n + 29);
    d2 = n + 29;
    send_at(d2 + 1, 1, 16, 14, m); push(22, d2 + 14);
    wait_idle("b2b");
  endtask

  task automatic test_mid_reset();
    int n;
    do_reset();
    send(1, 10, 10, n); wait_idle("mrst_seed");
    send(1, 12, 11, n);
    repeat (4) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    checks += 4;
    if (bus.BUSY !== 1'b0) $display("FAIL mrst_busy got %b want 0", bus.BUSY); else passes++;
    if (bus.TRACKING !== 1'b0) $display("FAIL mrst_tracking got %b want 0", bus.TRACKING); else passes++;
    if (bus.TARGET_Y !== 5'd15) $display("FAIL mrst_target got %0d want 15", bus.TARGET_Y); else passes++;
    if (bus.VEL_X !== 7'd0 || bus.VEL_Y !== 7'd0)
      $display("FAIL mrst_vel got %0d,%0d want 0,0", bus.VEL_X, bus.VEL_Y); else passes++;
    @(negedge CLK);
    RST = 1'b0;
    repeat (30) @(negedge CLK);
    checks++;
    if (sb.size() != 0) $display("FAIL final_queue got %0d left want 0", sb.size()); else passes++;
  endtask

  initial begin
    bus.BALL_VALID = 1'b0;
    bus.BALL_FOUND = 1'b0;
    bus.BALL_X     = '0;
    bus.BALL_Y     = '0;
    test_reset();
    test_straight();
    test_bounce();
    test_away();
    test_clamp();
    test_track_loss();
    test_jump();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
